mul_share_ctrl: RTL and testbench
=================================

// Module: mul_share_ctrl
// PURPOSE
//  Shares one 32x32 multiplier (low-32-bit product, external combinational Multi instance) among NREQ requesters.
//  Round-robin arbitration, operand registering, MUL_LAT-cycle settle wait, result hold until the requester accepts.
//  Sits between ALU-side requesters and the single multiplier datapath; one operation in flight at a time.
// PARAMETERS
//  NREQ     4   number of requesters (2..8)
//  DATA_W   32  operand/product width
//  MUL_LAT  2   cycles operands are held stable on mul_a/mul_b before mul_p is sampled (1..15)
// PORTS
//  clk         in   1              single clock, rising edge
//  rst_n       in   1              asynchronous, active-low reset
//  req_valid   in   NREQ           per-requester operation request
//  req_ready   out  NREQ           one-hot accept strobe
//  req_a       in   NREQ*DATA_W    operand A; requester i at [i*DATA_W +: DATA_W]
//  req_b       in   NREQ*DATA_W    operand B; same packing
//  resp_valid  out  NREQ           one-hot result valid, to the owning requester only
//  resp_ready  in   NREQ           per-requester result accept
//  resp_data   out  DATA_W         product, low DATA_W bits
//  mul_a       out  DATA_W         to multiplier input a
//  mul_b       out  DATA_W         to multiplier input b
//  mul_p       in   DATA_W         from multiplier output
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, rr_ptr=0, cnt=0, op/result/id regs=0; all outputs 0.
//  States: IDLE -> BUSY -> RESP -> IDLE.
//  IDLE:
//   - grant = first i with req_valid[i], searching from rr_ptr upward, wrapping at NREQ.
//   - req_ready[grant]=1 combinationally in the same cycle (only in IDLE; 0 in all other states).
//   - On accept (cycle T): latch op_a/op_b/id, rr_ptr<=grant+1 mod NREQ, cnt<=MUL_LAT-1, go BUSY.
//   - No req_valid: remain IDLE, rr_ptr unchanged.
//  BUSY:
//   - mul_a/mul_b = op_a/op_b (registered, stable for the whole op); cnt decrements each cycle.
//   - When cnt==0: result<=mul_p, go RESP.
//   - Entered at T+1; lasts exactly MUL_LAT cycles.
//  RESP:
//   - resp_valid[id]=1 first at T+MUL_LAT+1; resp_data=result, held stable until handshake.
//   - resp_valid[id]&&resp_ready[id] -> IDLE next cycle. resp_ready of other requesters is ignored.
//  mul_a/mul_b keep op regs in IDLE and RESP (no toggling). resp_data=result register at all times.
//  Throughput: one op per MUL_LAT+2 cycles minimum (accept, MUL_LAT busy, 1+ resp).
//  Arithmetic: result = (op_a*op_b) mod 2^DATA_W, unsigned; overflow silently truncated, no flag.
//  Boundaries:
//   - requester drops req_valid before grant: no effect.
//   - req_valid stays high after accept: not re-granted until IDLE, then competes normally.
//   - all NREQ requesting continuously: grants rotate 0,1,..,NREQ-1,0 (no starvation).
//   - resp_ready held high before result: completes on first resp_valid cycle.
//   - rst_n low mid-BUSY/RESP: op discarded, no resp_valid ever for it, rr_ptr=0.
//   - MUL_LAT outside 1..15: elaboration error.
// STRUCTURE
//  Shared include mul_defs.vh:
//   - state encodings IDLE=2'd0, BUSY=2'd1, RESP=2'd2
//   - DATA_W default
//   - CNT_W=4
//  Sub-module rr_arbiter (NREQ, req, ptr -> one-hot grant, grant index).
//  Controller FSM and registers in mul_share_ctrl; multiplier instantiated by the parent, not here.
// TESTING
//  Bench instantiates mul_share_ctrl + Multi; checker compares each response to (a*b)[31:0], $fatal on mismatch.
//  1) Single op: req0 a=7,b=6 -> req_ready[0] at T; resp_valid[0] at T+3 (MUL_LAT=2), resp_data=42.
//  2) Wrap: a=32'hFFFFFFFF, b=2 -> resp_data=32'hFFFFFFFE; a=32'h80000000, b=2 -> 0.
//  3) Fairness: all 4 req_valid held high, resp_ready=1111
//     -> grant order 0,1,2,3,0; each op 4 cycles apart.
//  4) Back-pressure: resp_ready[1]=0 for 10 cycles -> resp_valid[1], resp_data stable;
//     req_ready stays 0; completes when resp_ready[1] raised.
//  5) Reset mid-BUSY: drop rst_n one cycle after accept of req2 -> outputs 0 immediately;
//     no response for req2; next grant to req0.
//  6) Random: 100 ops, random valids/ready stalls, $random operands
//     -> every response correct, routed to the right id, none lost or duplicated.

Source files
------------

// File: rtl/mul_share_ctrl_pkg.sv
// Shared types and constants for the shared-multiplier controller.
// Holds the FSM state encoding, counter width and the round-robin wrap helper.
package mul_share_ctrl_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int CNT_W       = 4;
  localparam int MUL_LAT_MIN = 1;
  localparam int MUL_LAT_MAX = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  // Position reached by stepping 'off' slots from 'base' on a ring of 'n' requesters.
  function automatic int rr_wrap(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/mul_share_ctrl_rr_arbiter.sv
// Round-robin arbiter: picks the first active request at or above the pointer,
// wrapping around, and reports it both one-hot and as an index.
module mul_share_ctrl_rr_arbiter
  import mul_share_ctrl_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int PTR_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [NREQ-1:0]  grant_o,
  output logic [PTR_W-1:0] grant_idx_o,
  output logic             valid_o
);

  logic [PTR_W-1:0] probe;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    valid_o     = 1'b0;
    probe       = '0;
    for (int k = 0; k < NREQ; k++) begin
      probe = PTR_W'(rr_wrap(int'(ptr_i), k, NREQ));
      if (!valid_o && req_i[probe]) begin
        valid_o     = 1'b1;
        grant_idx_o = probe;
      end
    end
    if (valid_o) grant_o[grant_idx_o] = 1'b1;
  end

endmodule

// File: rtl/mul_share_ctrl.sv
// Time-shares one external combinational multiplier among NREQ requesters:
// round-robin accept, registered operands, MUL_LAT settle cycles, held result.
module mul_share_ctrl
  import mul_share_ctrl_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int MUL_LAT = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic [NREQ-1:0]        req_valid_i,
  output logic [NREQ-1:0]        req_ready_o,
  input  logic [NREQ*DATA_W-1:0] req_a_i,
  input  logic [NREQ*DATA_W-1:0] req_b_i,
  output logic [NREQ-1:0]        resp_valid_o,
  input  logic [NREQ-1:0]        resp_ready_i,
  output logic [DATA_W-1:0]      resp_data_o,
  output logic [DATA_W-1:0]      mul_a_o,
  output logic [DATA_W-1:0]      mul_b_o,
  input  logic [DATA_W-1:0]      mul_p_i
);

  localparam int PTR_W = $clog2(NREQ);

  if (MUL_LAT < MUL_LAT_MIN || MUL_LAT > MUL_LAT_MAX) begin : g_bad_lat
    $error("mul_share_ctrl: MUL_LAT must be within 1..15");
  end
  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("mul_share_ctrl: NREQ must be within 2..8");
  end

  state_e              state_q, state_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   op_a_q, op_a_d;
  logic [DATA_W-1:0]   op_b_q, op_b_d;
  logic [PTR_W-1:0]    id_q, id_d;
  logic [DATA_W-1:0]   result_q, result_d;

  logic [NREQ-1:0]     arb_grant;
  logic [PTR_W-1:0]    arb_idx;
  logic                arb_valid;
  logic [DATA_W-1:0]   sel_a, sel_b;

  mul_share_ctrl_rr_arbiter #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .req_i       (req_valid_i),
    .ptr_i       (rr_ptr_q),
    .grant_o     (arb_grant),
    .grant_idx_o (arb_idx),
    .valid_o     (arb_valid)
  );

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_idx == PTR_W'(i)) begin
        sel_a = req_a_i[i*DATA_W +: DATA_W];
        sel_b = req_b_i[i*DATA_W +: DATA_W];
      end
    end
  end

  // The counter is loaded with MUL_LAT-1 on accept so BUSY lasts exactly MUL_LAT cycles.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    id_d     = id_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          op_a_d   = sel_a;
          op_b_d   = sel_b;
          id_d     = arb_idx;
          rr_ptr_d = (arb_idx == PTR_W'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
          cnt_d    = CNT_W'(MUL_LAT - 1);
          state_d  = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          result_d = mul_p_i;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (resp_ready_i[id_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      id_q     <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      id_q     <= id_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    req_ready_o  = (state_q == IDLE) ? arb_grant : '0;
    resp_valid_o = '0;
    if (state_q == RESP) resp_valid_o[id_q] = 1'b1;
  end

  assign resp_data_o = result_q;
  assign mul_a_o     = op_a_q;
  assign mul_b_o     = op_b_q;

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Directed and randomised bench for mul_share_ctrl with a behavioural multiplier.
// Expected grants, latencies and products are worked out independently of the DUT.
module tb_mul_share_ctrl;

  localparam int NREQ = 4;
  localparam int DW   = 32;
  localparam int LAT  = 2;

  logic                 clk;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*DW-1:0]   req_a;
  logic [NREQ*DW-1:0]   req_b;
  logic [NREQ-1:0]      resp_valid;
  logic [NREQ-1:0]      resp_ready;
  logic [DW-1:0]        resp_data;
  logic [DW-1:0]        mul_a;
  logic [DW-1:0]        mul_b;
  logic [DW-1:0]        mul_p;

  int checks = 0;
  int errors = 0;
  int ptrModel;

  mul_share_ctrl #(
    .NREQ    (NREQ),
    .DATA_W  (DW),
    .MUL_LAT (LAT)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_a_i      (req_a),
    .req_b_i      (req_b),
    .resp_valid_o (resp_valid),
    .resp_ready_i (resp_ready),
    .resp_data_o  (resp_data),
    .mul_a_o      (mul_a),
    .mul_b_o      (mul_b),
    .mul_p_i      (mul_p)
  );

  assign mul_p = mul_a * mul_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] valid, input logic [NREQ-1:0] ready);
    req_valid  = valid;
    resp_ready = ready;
    #1;
  endtask

  task automatic setOp(input int id, input logic [31:0] a, input logic [31:0] b);
    req_a[id*DW +: DW] = a;
    req_b[id*DW +: DW] = b;
  endtask

  // Single op with resp_ready already high, so it completes on the first resp_valid cycle.
  task automatic runOp(input int id, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp);
    logic [NREQ-1:0] sel;
    sel = 4'(1 << id);
    setOp(id, a, b);
    applyStimulus(sel, sel);
    checkOutput("op_grant", 32'(req_ready), 32'(sel));
    step();
    applyStimulus('0, sel);
    checkOutput("op_busy1_valid", 32'(resp_valid), 32'd0);
    checkOutput("op_mul_a", mul_a, a);
    checkOutput("op_mul_b", mul_b, b);
    step();
    checkOutput("op_busy2_valid", 32'(resp_valid), 32'd0);
    step();
    checkOutput("op_resp_valid", 32'(resp_valid), 32'(sel));
    checkOutput("op_resp_data", resp_data, exp);
    step();
    checkOutput("op_done_valid", 32'(resp_valid), 32'd0);
  endtask

  initial begin
    rst_n      = 1'b1;
    req_valid  = '0;
    resp_ready = '0;
    req_a      = '0;
    req_b      = '0;
    #1 rst_n = 1'b0;
    #1;
    $display("[TB] reset state");
    checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("rst_resp_data", resp_data, 32'd0);
    checkOutput("rst_mul_a", mul_a, 32'd0);
    checkOutput("rst_mul_b", mul_b, 32'd0);
    step();
    rst_n = 1'b1;
    step();

    $display("[TB] single op and wrap-around products");
    runOp(0, 32'd7, 32'd6, 32'd42);
    runOp(2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE);
    runOp(3, 32'h8000_0000, 32'd2, 32'h0000_0000);

    $display("[TB] fairness with all requesters active");
    for (int i = 0; i < NREQ; i++) setOp(i, 32'(i + 1), 32'd10);
    applyStimulus(4'hF, 4'hF);
    for (int k = 0; k < 5; k++) begin
      checkOutput("fair_grant", 32'(req_ready), 32'(1 << (k % 4)));
      step();
      step();
      step();
      checkOutput("fair_resp_valid", 32'(resp_valid), 32'(1 << (k % 4)));
      checkOutput("fair_resp_data", resp_data, 32'((k % 4 + 1) * 10));
      if (k == 4) applyStimulus('0, 4'hF);
      step();
    end

    $display("[TB] back-pressure on requester 1");
    setOp(1, 32'd1000, 32'd3);
    applyStimulus(4'b0010, 4'b0000);
    checkOutput("bp_grant", 32'(req_ready), 32'b0010);
    step();
    applyStimulus(4'b0001, 4'b1101);
    step();
    step();
    for (int c = 0; c < 10; c++) begin
      checkOutput("bp_resp_valid", 32'(resp_valid), 32'b0010);
      checkOutput("bp_resp_data", resp_data, 32'd3000);
      checkOutput("bp_req_ready", 32'(req_ready), 32'd0);
      step();
    end
    applyStimulus(4'b0001, 4'b1111);
    checkOutput("bp_last_valid", 32'(resp_valid), 32'b0010);
    step();
    checkOutput("bp_done_valid", 32'(resp_valid), 32'd0);
    checkOutput("bp_next_grant", 32'(req_ready), 32'b0001);
    applyStimulus('0, 4'hF);
    step();

    $display("[TB] reset during BUSY");
    setOp(2, 32'd5, 32'd5);
    applyStimulus(4'b0100, 4'hF);
    checkOutput("rb_grant", 32'(req_ready), 32'b0100);
    step();
    req_valid = '0;
    rst_n     = 1'b0;
    #1;
    checkOutput("rb_mul_a", mul_a, 32'd0);
    checkOutput("rb_resp_data", resp_data, 32'd0);
    checkOutput("rb_resp_valid", 32'(resp_valid), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    setOp(0, 32'd9, 32'd9);
    applyStimulus(4'hF, 4'hF);
    checkOutput("rb_next_grant", 32'(req_ready), 32'b0001);
    step();
    applyStimulus('0, 4'hF);
    for (int c = 0; c < LAT; c++) begin
      checkOutput("rb_no_stale_resp", 32'(resp_valid), 32'd0);
      step();
    end
    checkOutput("rb_resp_valid0", 32'(resp_valid), 32'b0001);
    checkOutput("rb_resp_data0", resp_data, 32'd81);
    step();
    ptrModel = 1;

    $display("[TB] randomised operations");
    for (int n = 0; n < 40; n++) begin
      logic [NREQ-1:0] v;
      logic [NREQ-1:0] sel;
      logic [31:0]     expP;
      int              g;
      int              stall;
      v = 4'($urandom_range(1, 15));
      for (int i = 0; i < NREQ; i++) setOp(i, $urandom, $urandom);
      g = -1;
      for (int k = 0; k < NREQ; k++)
        if (g < 0 && v[(ptrModel + k) % NREQ]) g = (ptrModel + k) % NREQ;
      sel  = 4'(1 << g);
      expP = req_a[g*DW +: DW] * req_b[g*DW +: DW];
      applyStimulus(v, 4'($urandom) & ~sel);
      checkOutput("rnd_grant", 32'(req_ready), 32'(sel));
      step();
      setOp(g, $urandom, $urandom);
      applyStimulus(4'($urandom), resp_ready);
      checkOutput("rnd_busy_ready", 32'(req_ready), 32'd0);
      step();
      step();
      stall = $urandom_range(0, 3);
      for (int s = 0; s < stall; s++) begin
        checkOutput("rnd_stall_valid", 32'(resp_valid), 32'(sel));
        checkOutput("rnd_stall_data", resp_data, expP);
        step();
      end
      applyStimulus(req_valid, resp_ready | sel);
      checkOutput("rnd_resp_valid", 32'(resp_valid), 32'(sel));
      checkOutput("rnd_resp_data", resp_data, expP);
      step();
      checkOutput("rnd_done_valid", 32'(resp_valid), 32'd0);
      ptrModel = (g + 1) % NREQ;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
